// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write and read controllers.
// Gray/binary conversion and depth derivation for ADDR_SIZE-bit RAMs.
package fifo_ptr_pkg;

  function automatic int unsigned depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bits at or above width are ignored so callers may pass any narrower pointer.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
    logic [31:0] gm;
    logic [31:0] b;
    gm = g;
    for (int i = 0; i < 32; i++) begin
      if (i >= width) gm[i] = 1'b0;
    end
    b = gm;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary converter, each bit the XOR of all Gray bits at or above it.
// Zero latency; no flow control.
module gray2bin_comb #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/wptr_full_level.sv
// Write-side pointer/flag controller of the async FIFO (wclk domain): Gray/binary
// pointers, registered full, almost-full, fill level and sticky overflow.
module wptr_full_level
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_SIZE = 4
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic [ADDR_SIZE:0]   wafull_lvl,
  input  logic                 wovf_clr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 wafull,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 wovf
);

  localparam int A = ADDR_SIZE;

  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wptr_q, wptr_d;
  logic [A:0] wlevel_q, wlevel_d;
  logic       wfull_q, wfull_d;
  logic       wafull_q, wafull_d;
  logic       wovf_q, wovf_d;
  logic       wen;
  logic [A:0] rbin_s;

  gray2bin_comb #(.W(A + 1)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin_s)
  );

  always_comb begin
    wen      = winc & ~wfull_q;
    wbin_d   = wbin_q + {{A{1'b0}}, wen};
    wptr_d   = (A+1)'(bin2gray(32'(wbin_d)));
    // Modulo subtraction keeps the level valid across the pointer wrap.
    wlevel_d = wbin_d - rbin_s;
    wfull_d  = (wptr_d == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
    wafull_d = (wlevel_d >= wafull_lvl);
    // Set has priority over clear so a coincident dropped write is never lost.
    wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr  = wbin_q[A-1:0];
  assign wptr   = wptr_q;
  assign wfull  = wfull_q;
  assign wafull = wafull_q;
  assign wlevel = wlevel_q;
  assign wovf   = wovf_q;

endmodule
